// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin front end for a bus core chain.
// One transaction is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional feature: define BUS_ARB_TIMEOUT_EN to add a WAIT-cycle timeout
// that completes the transaction with rdata=0 and err=1.
module bus_arbiter #(
  parameter int TIMEOUT   = 16,
  parameter int PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req0_rw,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [15:0] resp0_rdata,
  output logic        resp0_err,
  input  logic        req1_valid,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  input  logic        req1_rw,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [15:0] resp1_rdata,
  output logic        resp1_err,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o,
  output logic        rw_o,
  output logic        valid_o,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        w_gnt, w_hs, w_match, w_tmo, w_done;
  logic [15:0] r_addr, r_wdata;
  logic        r_rw, r_owner, r_last;
  logic [15:0] r_rdata0, r_rdata1;
  logic        w_unused;

  // Lone requester wins; on a tie the one not served last wins
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) w_gnt = ~r_last;
    else if (req1_valid)          w_gnt = 1'b1;
  end

  assign w_hs    = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
  assign w_match = (r_state == S_WAIT) && valid_i && (addr_i == r_addr) && (rw_i == r_rw);
  assign w_done  = w_match || w_tmo;
  assign rdata_o = '0;

  // Next state and all state-decoded outputs; bus outputs are zero outside ISSUE
  always_comb begin
    w_next      = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    valid_o     = 1'b0;
    addr_o      = '0;
    wdata_o     = '0;
    rw_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && !w_gnt;
          req1_ready = req1_valid &&  w_gnt;
        end
        if (w_hs) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        valid_o = 1'b1;
        addr_o  = r_addr;
        wdata_o = r_wdata;
        rw_o    = r_rw;
        w_next  = S_WAIT;
      end
      S_WAIT: if (w_done) w_next = S_RESP;
      S_RESP: begin
        resp0_valid = !r_owner;
        resp1_valid =  r_owner;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Capture the granted request on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= 1'b0;
      r_owner <= 1'b0;
    end else if (w_hs) begin
      r_addr  <= w_gnt ? req1_addr  : req0_addr;
      r_wdata <= w_gnt ? req1_wdata : req0_wdata;
      r_rw    <= w_gnt ? req1_rw    : req0_rw;
      r_owner <= w_gnt;
    end
  end

  // Last-grant starts at the non-priority requester so PRIO_INIT wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_last <= (PRIO_INIT == 0);
    else if (r_state == S_RESP)  r_last <= r_owner;
  end

  // Per-requester response data, held until that requester's next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_done) begin
      if (r_owner) r_rdata1 <= w_match ? rdata_i : '0;
      else         r_rdata0 <= w_match ? rdata_i : '0;
    end
  end

  assign resp0_rdata = r_rdata0;
  assign resp1_rdata = r_rdata1;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err0, r_err1;

  // A match on the last allowed cycle still wins over the timeout
  assign w_tmo = (r_state == S_WAIT) && !w_match && (r_cnt == CW'(TIMEOUT - 1));

  // Count WAIT cycles; cleared whenever not waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
    else                        r_cnt <= '0;
  end

  // Error flag travels with the response data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else if (w_done) begin
      if (r_owner) r_err1 <= !w_match;
      else         r_err0 <= !w_match;
    end
  end

  assign resp0_err = r_err0;
  assign resp1_err = r_err1;
  assign w_unused  = ^wdata_i;
`else
  assign w_tmo     = 1'b0;
  assign resp0_err = 1'b0;
  assign resp1_err = 1'b0;
  assign w_unused  = ^{wdata_i, (TIMEOUT > 0)};
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin model.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_rw, req1_valid, req1_rw, rw_i, valid_i;
  logic [15:0] req0_addr, req0_wdata, req1_addr, req1_wdata, addr_i, wdata_i, rdata_i;
  logic        req0_ready, resp0_valid, resp0_err, req1_ready, resp1_valid, resp1_err;
  logic [15:0] resp0_rdata, resp1_rdata, addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o;
  int          checks = 0;
  int          errors = 0;

  wire [87:0] outs_all = {req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_rdata,
                          resp1_rdata, resp0_err, resp1_err, addr_o, wdata_o, rdata_o,
                          rw_o, valid_o};

  bus_arbiter #(.TIMEOUT(16), .PRIO_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rw(req0_rw),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rw(req1_rw),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int n, input logic v, input logic [15:0] a,
                         input logic [15:0] d, input logic rw);
    if (n == 0) begin
      req0_valid = v; req0_addr = a; req0_wdata = d; req0_rw = rw;
    end else begin
      req1_valid = v; req1_addr = a; req1_wdata = d; req1_rw = rw;
    end
  endtask

  task automatic set_ret(input logic v, input logic [15:0] a, input logic [15:0] rd,
                         input logic rw);
    valid_i = v; addr_i = a; rdata_i = rd; wdata_i = rd; rw_i = rw;
  endtask

  task automatic clr();
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
    set_ret(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; clr();
    step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    clr(); req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++; if (outs_all !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs_all); end
    step(); rst = 1'b0;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++;
      $display("FAIL reset_first_tie: ready{1,0} got %b want 01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_read();
    do_reset();
    set_req(0, 1'b1, 16'h0012, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++;
      $display("FAIL read_ready: got %b want 01", {req1_ready, req0_ready}); end
    step(); set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({valid_o, addr_o, rw_o, rdata_o, req0_ready} !== {1'b1, 16'h0012, 1'b0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL read_issue: valid %b addr %h rw %b rdata %h rdy %b", valid_o, addr_o, rw_o, rdata_o, req0_ready); end
    step(); set_ret(1'b1, 16'h0012, 16'hBEEF, 1'b0);
    @(negedge clk);
    checks++; if ({valid_o, addr_o, resp0_valid} !== '0) begin errors++;
      $display("FAIL read_wait: valid_o %b addr_o %h resp0 %b want 0", valid_o, addr_o, resp0_valid); end
    step(); set_ret(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({resp0_valid, resp0_rdata, resp0_err, resp1_valid} !== {1'b1, 16'hBEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL read_resp: v0 %b rd %h err %b v1 %b want 1 beef 0 0", resp0_valid, resp0_rdata, resp0_err, resp1_valid); end
    step();
    @(negedge clk);
    checks++; if ({resp0_valid, resp0_rdata} !== {1'b0, 16'hBEEF}) begin errors++;
      $display("FAIL read_hold: v0 %b rd %h want 0 beef", resp0_valid, resp0_rdata); end
  endtask

  task automatic test_round_robin();
    int w, last;
    logic [1:0] e;
    do_reset(); last = 1;
    set_req(0, 1'b1, 16'h0100, 16'h0, 1'b0);
    set_req(1, 1'b1, 16'h0200, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = 1 - last;
      e = (w == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== e) begin errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, {req1_ready, req0_ready}, e); end
      step(); step();
      set_ret(1'b1, (w == 1) ? 16'h0200 : 16'h0100, 16'(i), 1'b0);
      step(); set_ret(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      checks++; if ({resp1_valid, resp0_valid} !== e) begin errors++;
        $display("FAIL rr_resp[%0d]: got %b want %b", i, {resp1_valid, resp0_valid}, e); end
      last = w;
      step();
    end
    clr();
  endtask

  task automatic test_mismatch();
    do_reset();
    set_req(0, 1'b1, 16'h0012, 16'h0, 1'b0);
    step(); set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(); set_ret(1'b1, 16'h0013, 16'hDEAD, 1'b0);
    step(); set_ret(1'b1, 16'h0012, 16'hDEAD, 1'b1);
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL mm_addr: resp0 %b want 0", resp0_valid); end
    step(); set_ret(1'b1, 16'h0012, 16'h5A5A, 1'b0);
    @(negedge clk);
    checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL mm_rw: resp0 %b want 0", resp0_valid); end
    step(); set_ret(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({resp0_valid, resp0_rdata} !== {1'b1, 16'h5A5A}) begin errors++;
      $display("FAIL mm_done: v0 %b rd %h want 1 5a5a", resp0_valid, resp0_rdata); end
    step();
  endtask

  task automatic test_write();
    do_reset();
    set_req(1, 1'b1, 16'h0040, 16'h1234, 1'b1);
    step(); set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({valid_o, addr_o, wdata_o, rw_o, rdata_o} !== {1'b1, 16'h0040, 16'h1234, 1'b1, 16'h0}) begin
      errors++; $display("FAIL wr_issue: v %b a %h d %h rw %b rd %h", valid_o, addr_o, wdata_o, rw_o, rdata_o); end
    step();
    @(negedge clk);
    checks++; if ({valid_o, addr_o, wdata_o, rw_o} !== '0) begin errors++;
      $display("FAIL wr_bus_idle: v %b a %h d %h rw %b want 0", valid_o, addr_o, wdata_o, rw_o); end
    set_ret(1'b1, 16'h0040, 16'h1234, 1'b1);
    step(); set_ret(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({resp1_valid, resp1_rdata, resp0_valid} !== {1'b1, 16'h1234, 1'b0}) begin errors++;
      $display("FAIL wr_resp: v1 %b rd %h v0 %b want 1 1234 0", resp1_valid, resp1_rdata, resp0_valid); end
    step();
  endtask

  task automatic test_timeout_reset();
    int n;
    do_reset();
    set_req(0, 1'b1, 16'h0055, 16'h0, 1'b0);
    step(); set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL to_issue: valid_o %b want 1", valid_o); end
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      step(); @(negedge clk);
      checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL to_early[%0d]: resp0 %b want 0", k, resp0_valid); end
    end
    step(); @(negedge clk);
    checks++; if ({resp0_valid, resp0_rdata, resp0_err} !== {1'b1, 16'h0, 1'b1}) begin errors++;
      $display("FAIL to_resp: v %b rd %h err %b want 1 0000 1", resp0_valid, resp0_rdata, resp0_err); end
`else
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step(); @(negedge clk);
      if (resp0_valid || resp1_valid) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL no_timeout: %0d resp strobes want 0", n); end
`endif
    // reset while waiting, then a late matching return
    do_reset();
    set_req(0, 1'b1, 16'h0066, 16'h0, 1'b0);
    step(); set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (outs_all !== '0) begin errors++; $display("FAIL rst_mid: outputs %h want 0", outs_all); end
    step(); rst = 1'b0; set_ret(1'b1, 16'h0066, 16'h7777, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({resp0_valid, resp1_valid, valid_o} !== 3'b000) begin errors++;
        $display("FAIL rst_late_ret[%0d]: v0 %b v1 %b vo %b want 0", k, resp0_valid, resp1_valid, valid_o); end
      step();
    end
    set_ret(1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1, 1'b1, 16'h0080, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rst_next_grant: ready1 %b want 1", req1_ready); end
    step(); set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({valid_o, addr_o} !== {1'b1, 16'h0080}) begin errors++;
      $display("FAIL rst_next_issue: v %b a %h want 1 0080", valid_o, addr_o); end
    step(); set_ret(1'b1, 16'h0080, 16'h4242, 1'b0);
    step(); set_ret(1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({resp1_valid, resp1_rdata} !== {1'b1, 16'h4242}) begin errors++;
      $display("FAIL rst_next_resp: v1 %b rd %h want 1 4242", resp1_valid, resp1_rdata); end
    step();
  endtask

  task automatic test_random();
    int          w, last, lat, pick;
    bit          p[2];
    logic [15:0] a[2], d[2], held[2];
    logic        r[2];
    logic [15:0] rd;
    logic [1:0]  e;
    do_reset();
    last = 1; p[0] = 0; p[1] = 0; held[0] = '0; held[1] = '0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0; r[0] = 0; r[1] = 0;
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++)
        if (!p[n] && $urandom_range(0, 2) != 0) begin
          p[n] = 1; a[n] = 16'($urandom); d[n] = 16'($urandom); r[n] = 1'($urandom);
        end
      if (!p[0] && !p[1]) begin
        pick = $urandom_range(0, 1);
        p[pick] = 1; a[pick] = 16'($urandom); d[pick] = 16'($urandom); r[pick] = 1'($urandom);
      end
      set_req(0, p[0], a[0], d[0], r[0]);
      set_req(1, p[1], a[1], d[1], r[1]);
      if ($urandom_range(0, 3) == 0) set_ret(1'b1, a[0], 16'hFFFF, r[0]);
      else                           set_ret(1'b0, 16'h0, 16'h0, 1'b0);
      w = (p[0] && p[1]) ? 1 - last : (p[1] ? 1 : 0);
      e = (w == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== e) begin errors++;
        $display("FAIL rnd_grant[%0d]: got %b want %b", it, {req1_ready, req0_ready}, e); end
      step();
      p[w] = 0; set_req(w, 1'b0, a[w], d[w], r[w]);
      if ($urandom_range(0, 2) == 0) set_ret(1'b1, a[w], 16'hAAAA, r[w]);
      else                           set_ret(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      checks++; if ({valid_o, addr_o, wdata_o, rw_o, rdata_o, req0_ready, req1_ready} !==
                    {1'b1, a[w], d[w], r[w], 16'h0, 2'b00}) begin errors++;
        $display("FAIL rnd_issue[%0d]: v %b a %h d %h rw %b want 1 %h %h %b", it, valid_o, addr_o, wdata_o, rw_o, a[w], d[w], r[w]); end
      lat = $urandom_range(1, 4);
      for (int k = 0; k < lat - 1; k++) begin
        step();
        case ($urandom_range(0, 2))
          0:       set_ret(1'b0, 16'h0, 16'h0, 1'b0);
          1:       set_ret(1'b1, a[w] ^ 16'h0001, 16'h1111, r[w]);
          default: set_ret(1'b1, a[w], 16'h2222, ~r[w]);
        endcase
        @(negedge clk);
        checks++; if ({resp0_valid, resp1_valid, valid_o, req0_ready, req1_ready} !== 5'b0) begin errors++;
          $display("FAIL rnd_wait[%0d]: v0 %b v1 %b vo %b want 0", it, resp0_valid, resp1_valid, valid_o); end
      end
      step(); rd = 16'($urandom); set_ret(1'b1, a[w], rd, r[w]);
      step(); set_ret(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      checks++; if ({resp1_valid, resp0_valid, resp0_err, resp1_err, resp0_rdata, resp1_rdata} !==
                    {e, 2'b00, (w == 0) ? rd : held[0], (w == 1) ? rd : held[1]}) begin errors++;
        $display("FAIL rnd_resp[%0d]: v{1,0} %b rd0 %h rd1 %h want %b owner rd %h", it, {resp1_valid, resp0_valid}, resp0_rdata, resp1_rdata, e, rd); end
      held[w] = rd; last = w;
      step();
    end
    clr();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr();
    test_reset();
    test_read();
    test_round_robin();
    test_mismatch();
    test_write();
    test_timeout_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for a bus response.
REQ-002 SHALL have parameter PRIO_INIT, default 0: requester that wins the first tie after reset.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 reqN_valid (N=0,1)  in  1  requester N has a transaction pending.
REQ-006 reqN_addr, reqN_wdata  in  16 each  transaction address and write data.
REQ-007 reqN_rw  in  1  1=write, 0=read.
REQ-008 reqN_ready  out  1  transaction accepted this cycle when high with reqN_valid.
REQ-009 respN_valid  out  1  one-cycle response strobe to requester N.
REQ-010 respN_rdata  out  16  read data, or echoed rdata for writes.
REQ-011 respN_err  out  1  response was a timeout.
REQ-012 addr_o, wdata_o, rdata_o  out  16 each  bus request into head of core chain.
REQ-013 rw_o, valid_o  out  1 each  bus request type and strobe.
REQ-014 addr_i, wdata_i, rdata_i  in  16 each  bus return from tail of core chain.
REQ-015 rw_i, valid_i  in  1 each  bus return type and strobe.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with one outstanding transaction at a time.
REQ-017 In IDLE, reqN_ready SHALL be combinational: high only for the granted requester and only when state is IDLE; both low in all other states.
REQ-018 If one requester is valid in IDLE, it SHALL be granted; if both are valid, the one not granted last SHALL win (round-robin), with PRIO_INIT winning the first tie after reset.
REQ-019 On handshake, SHALL latch addr, wdata, rw and owner, then go to ISSUE.
REQ-020 In ISSUE (one cycle), SHALL drive valid_o=1 with latched addr_o/wdata_o/rw_o and rdata_o=0, then go to WAIT.
REQ-021 Outside ISSUE, SHALL drive valid_o=0 and SHALL hold addr_o/wdata_o/rw_o/rdata_o at 0.
REQ-022 In WAIT, a match SHALL be valid_i=1 with addr_i equal to the latched addr and rw_i equal to the latched rw; on match, SHALL capture rdata_i and go to RESP.
REQ-023 SHALL ignore non-matching valid_i and any valid_i seen outside WAIT.
REQ-024 In RESP (one cycle), SHALL assert respN_valid for the owner only, with captured rdata and err, update last-grant to the owner, then go to IDLE.
REQ-025 Minimum transaction time SHALL be 4 cycles from handshake to resp strobe when the chain latency is 1 cycle.
REQ-026 respN_rdata/respN_err SHALL hold their value until the next RESP for that requester.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE and set all outputs to 0, last-grant to the non-PRIO_INIT requester, and the timeout counter to 0.
REQ-028 Reset mid-transaction SHALL drop the transaction without generating any resp; a late matching valid_i after reset SHALL be ignored.
REQ-029 On the first clk edge after rst deasserts, SHALL evaluate arbitration normally.

Configuration
REQ-030 With macro BUS_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL run; after TIMEOUT WAIT cycles without a match, SHALL go to RESP with rdata=0 and err=1.
REQ-031 With BUS_ARB_TIMEOUT_EN undefined, SHALL have no counter, WAIT SHALL persist until a match, and respN_err SHALL be constant 0.

Verification
REQ-032 req0 read addr 0x0012, chain returns rdata 0xBEEF one cycle after valid_o -> resp0_valid one cycle later with rdata 0xBEEF, err 0; resp1_valid stays 0.
REQ-033 req0 and req1 both valid from reset with PRIO_INIT=0 -> req0 granted first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-034 Return with addr_i=0x0013 while 0x0012 is pending -> ignored; a later 0x0012 return completes the transaction.
REQ-035 rst asserted during WAIT, then matching return arrives -> no resp strobe, all outputs 0, IDLE grants the next request.
REQ-036 With BUS_ARB_TIMEOUT_EN and TIMEOUT=16, no return -> resp strobe with rdata 0x0000 and err=1 exactly 16 WAIT cycles later; without the macro, no resp after 100 cycles.
REQ-037 req1 write 0x0040 data 0x1234 -> valid_o one cycle with addr_o 0x0040, wdata_o 0x1234, rw_o 1; resp1_valid after the echo returns.
